// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator and its neighbours.
package sobel_pkg;

  localparam int PIXEL_W  = 8;
  localparam int WINDOW_W = 9 * PIXEL_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } wg_state_t;

endpackage

// File: rtl/line_buffer.sv
// One-line delay: o_dout is the sample written DEPTH shifts ago.
// The read-before-write circular buffer keeps each line buffer a single addressed array.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  // The slot about to be overwritten still holds the sample from one line ago.
  assign o_dout = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (i_shift_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_shift_en) begin
      if (r_ptr == AW'(DEPTH - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 pixel windows from a raster pixel stream using two chained line buffers.
// Only fully interior windows are emitted; border positions are skipped.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                valid_in,
  input  logic                sof,
  input  logic [PIXEL_W-1:0]  pixel_in,
  output logic                valid_out,
  output logic [WINDOW_W-1:0] pixels_3x3,
  output logic                frame_done,
  output logic                busy
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  wg_state_t r_state;
  wg_state_t w_state_next;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [3*PIXEL_W-1:0]  r_c1;
  logic [3*PIXEL_W-1:0]  r_c2;
  logic [WINDOW_W-1:0]   r_pixels;
  logic                  r_valid_out;
  logic                  r_frame_done;

  logic                  w_take;
  logic [CW-1:0]         w_col;
  logic [RW-1:0]         w_row;
  logic                  w_eol;
  logic                  w_last;
  logic                  w_emit;
  logic [PIXEL_W-1:0]    w_lb0_dout;
  logic [PIXEL_W-1:0]    w_lb1_dout;
  logic [3*PIXEL_W-1:0]  w_c_new;
  logic [WINDOW_W-1:0]   w_win_next;

  // In IDLE only a sof pixel is taken; sof always re-anchors the pixel at (0,0).
  assign w_take = enable & valid_in & ((r_state != IDLE) | sof);
  assign w_col  = sof ? '0 : r_col;
  assign w_row  = sof ? '0 : r_row;
  assign w_eol  = (w_col == CW'(IMG_WIDTH - 1));
  assign w_last = w_eol & (w_row == RW'(IMG_HEIGHT - 1));
  assign w_emit = w_take & (w_row >= RW'(2)) & (w_col >= CW'(2));

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_W)
  ) u_lb0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_shift_en (w_take),
    .i_din      (pixel_in),
    .o_dout     (w_lb0_dout)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_W)
  ) u_lb1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_shift_en (w_take),
    .i_din      (w_lb0_dout),
    .o_dout     (w_lb1_dout)
  );

  // Column words are {top, middle, bottom}; the window is assembled row by row.
  assign w_c_new    = {w_lb1_dout, w_lb0_dout, pixel_in};
  assign w_win_next = {r_c1[23:16], r_c2[23:16], w_c_new[23:16],
                       r_c1[15:8],  r_c2[15:8],  w_c_new[15:8],
                       r_c1[7:0],   r_c2[7:0],   w_c_new[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_take) w_state_next = FILL;
      end
      FILL: begin
        if (w_take) begin
          if (sof) begin
            w_state_next = FILL;
          end else if ((w_row == RW'(2)) && (w_col == '0)) begin
            w_state_next = STREAM;
          end
        end
      end
      STREAM: begin
        if (w_take) begin
          if (sof) begin
            w_state_next = FILL;
          end else if (w_last) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_take) begin
      if (w_last) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_eol) begin
        r_col <= '0;
        r_row <= w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c1         <= '0;
      r_c2         <= '0;
      r_pixels     <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_emit;
      r_frame_done <= w_emit & w_last;
      if (w_take) begin
        r_c1 <= r_c2;
        r_c2 <= w_c_new;
      end
      if (w_emit) begin
        r_pixels <= w_win_next;
      end
    end
  end

  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;
  assign pixels_3x3 = r_pixels;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 frame with ramp pixels 16*row+col.
module tb_sobel_window_gen;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        valid_in;
  logic        sof;
  logic [7:0]  pixel_in;
  logic        valid_out;
  logic [71:0] pixels_3x3;
  logic        frame_done;
  logic        busy;

  int checks;
  int failures;

  sobel_window_gen #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .valid_in   (valid_in),
    .sof        (sof),
    .pixel_in   (pixel_in),
    .valid_out  (valid_out),
    .pixels_3x3 (pixels_3x3),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w = {w[63:0], 8'(16 * (r - 2 + i) + (c - 2 + j))};
      end
    end
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; valid_in = 1'b0; sof = 1'b0; pixel_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (pixels_3x3 !== 72'h0) begin failures++; $display("FAIL reset_pixels got=%h exp=0", pixels_3x3); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp(input int gap);
    int          nwin;
    logic        ev;
    logic        ef;
    nwin = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        enable = 1'b1; valid_in = 1'b1; sof = (r == 0 && c == 0); pixel_in = 8'(16 * r + c);
        @(negedge clk);
        valid_in = 1'b0; sof = 1'b0;
        ev = (r >= 2 && c >= 2);
        ef = (r == 3 && c == 3);
        checks++; if (valid_out !== ev) begin failures++; $display("FAIL ramp_valid gap=%0d r=%0d c=%0d got=%b exp=%b", gap, r, c, valid_out, ev); end
        if (ev) begin
          nwin++;
          $display("ramp gap=%0d window r=%0d c=%0d data=%h", gap, r, c, pixels_3x3);
          checks++; if (pixels_3x3 !== exp_win(r, c)) begin failures++; $display("FAIL ramp_window gap=%0d r=%0d c=%0d got=%h exp=%h", gap, r, c, pixels_3x3, exp_win(r, c)); end
        end
        checks++; if (frame_done !== ef) begin failures++; $display("FAIL ramp_done gap=%0d r=%0d c=%0d got=%b exp=%b", gap, r, c, frame_done, ef); end
        if (r == 1 && c == 0) begin
          checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ramp_busy_mid got=%b exp=1", busy); end
        end
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL gap_valid r=%0d c=%0d got=%b exp=0", r, c, valid_out); end
        end
      end
    end
    checks++; if (nwin != 4) begin failures++; $display("FAIL ramp_count gap=%0d got=%0d exp=4", gap, nwin); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ramp_busy_end got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (valid_out !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL ramp_after got=%b%b exp=00", valid_out, frame_done); end
  endtask

  task automatic test_idle_discard();
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1; valid_in = 1'b1; sof = 1'b0; pixel_in = 8'(100 + i);
      @(negedge clk);
      checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_discard i=%0d got=%b%b exp=00", i, valid_out, busy); end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_abort();
    logic ev;
    logic ef;
    int   nwin;
    nwin = 0;
    for (int i = 0; i < 9; i++) begin
      enable = 1'b1; valid_in = 1'b1; sof = (i == 0); pixel_in = 8'(200 + i);
      @(negedge clk);
      valid_in = 1'b0; sof = 1'b0;
      checks++; if (valid_out !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL abort_pre i=%0d got=%b%b exp=00", i, valid_out, frame_done); end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        enable = 1'b1; valid_in = 1'b1; sof = (r == 0 && c == 0); pixel_in = 8'(16 * r + c);
        @(negedge clk);
        valid_in = 1'b0; sof = 1'b0;
        ev = (r >= 2 && c >= 2);
        ef = (r == 3 && c == 3);
        checks++; if (valid_out !== ev) begin failures++; $display("FAIL abort_valid r=%0d c=%0d got=%b exp=%b", r, c, valid_out, ev); end
        checks++; if (frame_done !== ef) begin failures++; $display("FAIL abort_done r=%0d c=%0d got=%b exp=%b", r, c, frame_done, ef); end
        if (ev) begin
          nwin++;
          $display("abort window r=%0d c=%0d data=%h", r, c, pixels_3x3);
          checks++; if (pixels_3x3 !== exp_win(r, c)) begin failures++; $display("FAIL abort_window r=%0d c=%0d got=%h exp=%h", r, c, pixels_3x3, exp_win(r, c)); end
        end
      end
    end
    checks++; if (nwin != 4) begin failures++; $display("FAIL abort_count got=%0d exp=4", nwin); end
  endtask

  task automatic test_enable_hold();
    logic ev;
    logic ef;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        enable = 1'b1; valid_in = 1'b1; sof = (r == 0 && c == 0); pixel_in = 8'(16 * r + c);
        @(negedge clk);
        valid_in = 1'b0; sof = 1'b0;
        ev = (r >= 2 && c >= 2);
        ef = (r == 3 && c == 3);
        checks++; if (valid_out !== ev) begin failures++; $display("FAIL hold_valid r=%0d c=%0d got=%b exp=%b", r, c, valid_out, ev); end
        checks++; if (frame_done !== ef) begin failures++; $display("FAIL hold_done r=%0d c=%0d got=%b exp=%b", r, c, frame_done, ef); end
        if (ev) begin
          $display("hold window r=%0d c=%0d data=%h", r, c, pixels_3x3);
          checks++; if (pixels_3x3 !== exp_win(r, c)) begin failures++; $display("FAIL hold_window r=%0d c=%0d got=%h exp=%h", r, c, pixels_3x3, exp_win(r, c)); end
        end
        if (r == 2 && c == 2) begin
          enable = 1'b0; valid_in = 1'b1; sof = 1'b1; pixel_in = 8'd99;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (valid_out !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL hold_flags k=%0d got=%b%b%b exp=001", k, valid_out, frame_done, busy); end
            checks++; if (pixels_3x3 !== exp_win(2, 2)) begin failures++; $display("FAIL hold_pixels k=%0d got=%h exp=%h", k, pixels_3x3, exp_win(2, 2)); end
          end
          valid_in = 1'b0; sof = 1'b0; enable = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 13; i++) begin
      enable = 1'b1; valid_in = 1'b1; sof = (i == 0); pixel_in = 8'(16 * (i / 4) + (i % 4));
      @(negedge clk);
    end
    pixel_in = 8'd49; sof = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b%b exp=000", valid_out, frame_done, busy); end
    checks++; if (pixels_3x3 !== 72'h0) begin failures++; $display("FAIL rstmid_pixels got=%h exp=0", pixels_3x3); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1; sof = 1'b0; pixel_in = 8'(i);
      @(negedge clk);
      checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_nosof i=%0d got=%b%b exp=00", i, valid_out, busy); end
    end
    valid_in = 1'b0;
    checks++; if (pixels_3x3 !== 72'h0) begin failures++; $display("FAIL rstmid_hold got=%h exp=0", pixels_3x3); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_ramp(0);
    test_ramp(3);
    test_idle_discard();
    test_abort();
    test_enable_hold();
    test_reset_mid();
    test_ramp(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
